// File: rtl/pr_request_dispatcher_pkg.sv
// Shared types for the PR request dispatcher: FSM states, request/completion
// layouts and completion status codes.
package pr_request_dispatcher_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_DECOUPLE,
    ST_REQ,
    ST_WAIT_DONE,
    ST_RECOUPLE,
    ST_WR,
    ST_WR_RESP
  } pr_dispatch_state_t;

  // Request slot is kept at full byte width so out-of-range slots can be detected.
  typedef struct packed {
    logic       valid;
    logic [7:0] accel_id;
    logic [7:0] slot;
  } pr_request_t;

  typedef struct packed {
    logic [7:0] slot;
    logic [7:0] accel_id;
    logic [1:0] status;
  } pr_completion_t;

  localparam logic [1:0] PR_STATUS_OK       = 2'd0;
  localparam logic [1:0] PR_STATUS_ERR      = 2'd1;
  localparam logic [1:0] PR_STATUS_TIMEOUT  = 2'd2;
  localparam logic [1:0] PR_STATUS_BAD_SLOT = 2'd3;

  function automatic logic [31:0] pack_completion(input pr_completion_t c);
    return {8'h00, c.slot, c.accel_id, 6'b000000, c.status};
  endfunction

endpackage

// File: rtl/pr_request_dispatcher_cycle_timer.sv
// Saturating up-counter held at zero while load is high; expired flags the
// last cycle of a LIMIT-cycle window that started when load dropped.
module pr_cycle_timer #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count_q <= '0;
    end else if (count_q != CW'(LIMIT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = !load && (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/pr_request_dispatcher.sv
// Pulls one PR request from the core queue, runs decouple / PR / recouple on the
// target slot and writes a completion word back. Define PR_DISPATCH_TIMEOUT_EN to bound the pr_done wait.
module pr_request_dispatcher
  import pr_request_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int unsigned DECOUPLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 65536,
  localparam int unsigned SLOT_W         = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pr_request_pending,
  output logic [1:0]           m_axi_awaddr,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [31:0]          m_axi_wdata,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  output logic [3:0]           m_axi_araddr,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [31:0]          m_axi_rdata,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready,
  output logic                 pr_req_valid,
  input  logic                 pr_req_ready,
  output logic [SLOT_W-1:0]    pr_req_slot,
  output logic [7:0]           pr_req_accel_id,
  input  logic                 pr_done,
  input  logic                 pr_error,
  output logic [NUM_SLOTS-1:0] decouple,
  output logic                 busy
);

  localparam logic [NUM_SLOTS-1:0] SLOT_ONE = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

  pr_dispatch_state_t   state_q, state_d;
  pr_completion_t       cpl_q, cpl_d;
  pr_request_t          req_in;
  logic                 arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d, pr_req_valid_d;
  logic [NUM_SLOTS-1:0] decouple_d;
  logic                 settle_expired;
  logic                 rdata_unused;

  assign req_in       = {m_axi_rdata[31], m_axi_rdata[15:8], m_axi_rdata[7:0]};
  assign rdata_unused = ^m_axi_rdata[30:16];

  assign m_axi_awaddr    = 2'b00;
  assign m_axi_araddr    = 4'h0;
  assign m_axi_wdata     = pack_completion(cpl_q);
  assign pr_req_slot     = cpl_q.slot[SLOT_W-1:0];
  assign pr_req_accel_id = cpl_q.accel_id;

  // One settle timer serves both decouple windows; it restarts on each entry.
  pr_cycle_timer #(.LIMIT(DECOUPLE_CYCLES)) u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    ((state_q != ST_DECOUPLE) && (state_q != ST_RECOUPLE)),
    .expired (settle_expired)
  );

`ifdef PR_DISPATCH_TIMEOUT_EN
  logic timeout_expired;

  pr_cycle_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q != ST_WAIT_DONE),
    .expired (timeout_expired)
  );
`else
  localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d        = state_q;
    cpl_d          = cpl_q;
    arvalid_d      = 1'b0;
    rready_d       = 1'b0;
    awvalid_d      = m_axi_awvalid;
    wvalid_d       = m_axi_wvalid;
    bready_d       = 1'b0;
    pr_req_valid_d = 1'b0;
    decouple_d     = decouple;
    case (state_q)
      ST_IDLE: begin
        if (pr_request_pending) begin
          state_d   = ST_RD_ADDR;
          arvalid_d = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (m_axi_arready) begin
          state_d  = ST_RD_DATA;
          rready_d = 1'b1;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      ST_RD_DATA: begin
        if (!m_axi_rvalid) begin
          rready_d = 1'b1;
        end else if (!req_in.valid) begin
          state_d = ST_IDLE;
        end else begin
          cpl_d.accel_id = req_in.accel_id;
          cpl_d.slot     = 8'(req_in.slot[SLOT_W-1:0]);
          // Out-of-range slots skip the PR cycle and report straight back.
          if (req_in.slot >= 8'(NUM_SLOTS)) begin
            cpl_d.status = PR_STATUS_BAD_SLOT;
            state_d      = ST_WR;
            awvalid_d    = 1'b1;
            wvalid_d     = 1'b1;
          end else begin
            cpl_d.status = PR_STATUS_OK;
            state_d      = ST_DECOUPLE;
            decouple_d   = SLOT_ONE << req_in.slot[SLOT_W-1:0];
          end
        end
      end
      ST_DECOUPLE: begin
        if (settle_expired) begin
          state_d        = ST_REQ;
          pr_req_valid_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (pr_req_ready) begin
          state_d = ST_WAIT_DONE;
        end else begin
          pr_req_valid_d = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (pr_done) begin
          cpl_d.status = pr_error ? PR_STATUS_ERR : PR_STATUS_OK;
          state_d      = ST_RECOUPLE;
          decouple_d   = '0;
        end
`ifdef PR_DISPATCH_TIMEOUT_EN
        else if (timeout_expired) begin
          cpl_d.status = PR_STATUS_TIMEOUT;
          state_d      = ST_RECOUPLE;
          decouple_d   = '0;
        end
`endif
      end
      ST_RECOUPLE: begin
        if (settle_expired) begin
          state_d   = ST_WR;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end
      end
      ST_WR: begin
        awvalid_d = m_axi_awvalid && !m_axi_awready;
        wvalid_d  = m_axi_wvalid && !m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WR_RESP;
          bready_d = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (m_axi_bvalid) begin
          state_d = ST_IDLE;
        end else begin
          bready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cpl_q         <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      pr_req_valid  <= 1'b0;
      decouple      <= '0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpl_q         <= cpl_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      pr_req_valid  <= pr_req_valid_d;
      decouple      <= decouple_d;
      busy          <= (state_d != ST_IDLE);
    end
  end

endmodule
